// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the two-requester memory port arbiter:
//   FSM state enum, requester-ID enum, MEM_LAT legal range, the muxed
//   request struct and a word-alignment helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 8;
  // Down-counter holds MEM_LAT-1, so MEM_LAT_MAX-1 must fit.
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX);

  // Winner's request after the ID mux.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Winner selection between instruction fetch and data requests.
//   Default build: data has fixed priority unless IF has waited through
//   STARVE_MAX consecutive data grants. With MEM_ARB_RR_EN defined the
//   pick is strict round-robin and STARVE_MAX is unused.
// Ports:
//   clk_i, rst_n  clock, async active-low reset
//   if_req, d_req pending requests
//   take          a grant is issued this cycle (updates history)
//   winner        requester that wins if a grant is issued
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic    clk_i,
  input  logic    rst_n,
  input  logic    if_req,
  input  logic    d_req,
  input  logic    take,
  output req_id_e winner
);

`ifdef MEM_ARB_RR_EN
  req_id_e last;

  // On contention, the requester that was not granted last wins.
  always_comb winner = (if_req && (!d_req || last == REQ_D)) ? REQ_IF : REQ_D;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)    last <= REQ_IF;
    else if (take) last <= winner;
  end
`else
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve;
  logic          starved;

  assign starved = if_req && (starve == SMAX);

  always_comb winner = (if_req && (!d_req || starved)) ? REQ_IF : REQ_D;

  // Counts data grants taken while IF is waiting; saturates, cleared by an IF grant.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (take) begin
      if (winner == REQ_IF)             starve <= '0;
      else if (if_req && starve != SMAX) starve <= starve + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-outstanding memory port between an instruction fetch
//   requester and a data (load/store) requester. Grants are combinational in
//   IDLE/DONE; WAIT counts out MEM_LAT; DONE pulses the owner's valid.
//   Optional macro MEM_ARB_RR_EN selects round-robin arbitration.
// Parameters: MEM_LAT (1..8) read latency, STARVE_MAX IF starvation limit.
// Ports:
//   clk_i, rst_n                      clock, async active-low reset
//   if_req_i/if_addr_i                fetch request and byte address
//   if_gnt_o/if_valid_o/if_rdata_o    fetch accept, completion, data
//   d_req_i/d_we_i/d_addr_i/d_wdata_i data request
//   d_gnt_o/d_valid_o/d_rdata_o       data accept, completion, load data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i  memory port
//   misalign_o                        sticky misaligned-access flag
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_valid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_valid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        misalign_o
);

  generate
    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT out of range 1..8");
    end
  endgenerate

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_e           state;
  logic [LAT_CNT_W-1:0] lat_cnt;
  req_id_e              owner;
  logic                 owner_we;
  logic [31:0]          if_rdata;
  logic [31:0]          d_rdata;
  logic                 misalign;

  req_id_e              winner;
  logic                 can_grant;
  logic                 take;
  mem_req_t             req;

  // Gated by rst_n so grant/strobe outputs read 0 while reset is held,
  // even with requests pending.
  assign can_grant = rst_n && (state == IDLE || state == DONE);
  assign take      = can_grant && (if_req_i || d_req_i);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .if_req (if_req_i),
    .d_req  (d_req_i),
    .take   (take),
    .winner (winner)
  );

  always_comb begin
    req = '0;
    if (winner == REQ_D) begin
      req.we    = d_we_i;
      req.addr  = d_addr_i;
      req.wdata = d_wdata_i;
    end else begin
      req.addr  = if_addr_i;
    end
  end

  assign if_gnt_o    = take && (winner == REQ_IF);
  assign d_gnt_o     = take && (winner == REQ_D);
  assign mem_en_o    = take;
  assign mem_we_o    = take && req.we;
  assign mem_addr_o  = take ? word_align(req.addr) : '0;
  assign mem_wdata_o = (take && req.we) ? req.wdata : '0;

  assign if_valid_o  = (state == DONE) && (owner == REQ_IF);
  assign d_valid_o   = (state == DONE) && (owner == REQ_D);
  assign if_rdata_o  = if_rdata;
  assign d_rdata_o   = d_rdata;
  assign misalign_o  = misalign;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      owner    <= REQ_IF;
      owner_we <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      misalign <= 1'b0;
    end else begin
      // take is only possible in IDLE/DONE, so it never collides with the WAIT count.
      if (take) begin
        owner    <= winner;
        owner_we <= req.we;
        lat_cnt  <= LAT_LOAD;
        if (req.addr[1:0] != 2'b00) misalign <= 1'b1;
      end
      case (state)
        IDLE, DONE: state <= take ? WAIT : IDLE;
        WAIT: begin
          if (lat_cnt == '0) begin
            // Memory data is valid on this edge; stores leave read data untouched.
            state <= DONE;
            if (!owner_we) begin
              if (owner == REQ_IF) if_rdata <= mem_rdata_i;
              else                 d_rdata  <= mem_rdata_i;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_i, if_gnt_o, if_valid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_valid_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        mem_en_o, mem_we_o, misalign_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // requester agents: 0 = directed only, 1 = random, 2 = always requesting
  logic        if_pend, d_pend, d_we;
  logic [31:0] if_a, d_a, d_wd;
  int          if_mode, d_mode;
  bit          allow_mis;

  // bmem answers the DUT's actual memory port; mmem is the model's view
  logic [31:0] bmem [16];
  logic [31:0] mmem [16];
  logic [31:0] rd_due [int];
  int          cyc;

  // transaction-level reference model
  int          free_at, starve, seq_d, run_len;
  bit          last_d, done_act, done_d, done_ld, m_mis;
  int          done_cyc;
  logic [31:0] done_data, m_if_rd, m_d_rd;

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    if (allow_mis && $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic model_reset();
    free_at = 0; starve = 0; last_d = 1'b0; done_act = 1'b0;
    m_if_rd = '0; m_d_rd = '0; m_mis = 1'b0;
    if_pend = 1'b0; d_pend = 1'b0; seq_d = 0;
    rd_due.delete();
  endtask

  task automatic gen_reqs();
    if (!if_pend && (if_mode == 2 || (if_mode == 1 && $urandom_range(0, 2) == 0))) begin
      if_pend = 1'b1; if_a = rand_addr();
    end
    if (!d_pend && (d_mode == 2 || (d_mode == 1 && $urandom_range(0, 1) == 0))) begin
      d_pend = 1'b1; d_we = 1'($urandom_range(0, 1)); d_a = rand_addr(); d_wd = $urandom;
    end
  endtask

  task automatic drive();
    if_req_i  = if_pend;
    if_addr_i = if_pend ? if_a : $urandom;
    d_req_i   = d_pend;
    d_we_i    = d_pend ? d_we : 1'($urandom_range(0, 1));
    d_addr_i  = d_pend ? d_a : $urandom;
    d_wdata_i = d_pend ? d_wd : $urandom;
    if (rd_due.exists(cyc)) begin
      mem_rdata_i = rd_due[cyc];
      rd_due.delete(cyc);
    end else begin
      mem_rdata_i = $urandom;
    end
  endtask

  task automatic model_check();
    bit          g_if, g_d, gwe, fin;
    logic [31:0] ga;
    fin = done_act && (cyc == done_cyc);
    if (fin && done_ld) begin
      if (done_d) m_d_rd = done_data;
      else        m_if_rd = done_data;
    end
    chk("if_valid", 32'(if_valid_o), 32'(fin && !done_d));
    chk("d_valid",  32'(d_valid_o),  32'(fin && done_d));
    chk("if_rdata", if_rdata_o, m_if_rd);
    chk("d_rdata",  d_rdata_o,  m_d_rd);
    chk("misalign", 32'(misalign_o), 32'(m_mis));
    if (fin) done_act = 1'b0;

    // one transaction at a time; the port frees up in the completion cycle
    g_if = 1'b0; g_d = 1'b0;
    if (cyc >= free_at && (if_pend || d_pend)) begin
`ifdef MEM_ARB_RR_EN
      g_if = (if_pend && d_pend) ? last_d : if_pend;
`else
      g_if = (if_pend && d_pend) ? (starve == STARVE_MAX) : if_pend;
`endif
      g_d = !g_if;
    end
    chk("if_gnt", 32'(if_gnt_o), 32'(g_if));
    chk("d_gnt",  32'(d_gnt_o),  32'(g_d));
    chk("mem_en", 32'(mem_en_o), 32'(g_if || g_d));
    if (g_if || g_d) begin
      ga  = g_d ? d_a : if_a;
      gwe = g_d && d_we;
      chk("mem_we",   32'(mem_we_o), 32'(gwe));
      chk("mem_addr", mem_addr_o, ga & 32'hFFFF_FFFC);
      if (gwe) chk("mem_wdata", mem_wdata_o, d_wd);
      if (ga[1:0] != 2'b00) m_mis = 1'b1;
      free_at   = cyc + MEM_LAT + 1;
      done_act  = 1'b1; done_cyc = cyc + MEM_LAT + 1;
      done_d    = g_d;  done_ld  = !gwe;
      done_data = mmem[ga[5:2]];
      if (gwe) mmem[ga[5:2]] = d_wd;
      if (g_if) starve = 0;
      else if (if_pend && starve < STARVE_MAX) starve++;
      last_d = g_d;
      if (g_if) if_pend = 1'b0; else d_pend = 1'b0;
    end

    if (mem_en_o) begin
      if (mem_we_o) bmem[mem_addr_o[5:2]] = mem_wdata_o;
      else          rd_due[cyc + MEM_LAT] = bmem[mem_addr_o[5:2]];
    end
    if (d_gnt_o) seq_d++;
    if (if_gnt_o) begin run_len = seq_d; seq_d = 0; end
  endtask

  // entered and left at posedge+1
  task automatic run(input int n);
    repeat (n) begin
      gen_reqs();
      drive();
      #2;
      model_check();
      @(posedge clk_i); #1;
      cyc++;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b1;
    if_addr_i = 32'h3; d_addr_i = 32'h7; d_wdata_i = 32'h1234_5678;
    #1;
    chk("rst_if_gnt",   32'(if_gnt_o),   32'd0);
    chk("rst_d_gnt",    32'(d_gnt_o),    32'd0);
    chk("rst_if_valid", 32'(if_valid_o), 32'd0);
    chk("rst_d_valid",  32'(d_valid_o),  32'd0);
    chk("rst_if_rdata", if_rdata_o,      32'd0);
    chk("rst_d_rdata",  d_rdata_o,       32'd0);
    chk("rst_mem_en",   32'(mem_en_o),   32'd0);
    chk("rst_mem_we",   32'(mem_we_o),   32'd0);
    chk("rst_mem_addr", mem_addr_o,      32'd0);
    chk("rst_mem_wdata", mem_wdata_o,    32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    model_reset();
    repeat (n) begin @(posedge clk_i); cyc++; end
    #1;
    if_req_i = 1'b0; d_req_i = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_run;
    cyc = 0; if_mode = 0; d_mode = 0; allow_mis = 1'b0; run_len = -1;
    if_a = '0; d_a = '0; d_wd = '0; d_we = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < 16; i++) begin bmem[i] = $urandom; mmem[i] = bmem[i]; end
    do_reset(3);

    // single fetch of 0x8
    bmem[2] = 32'hCAFE_0008; mmem[2] = 32'hCAFE_0008;
    if_pend = 1'b1; if_a = 32'h8;
    run(6);

    // simultaneous fetch and lw 0x10: data first, IF in the load's DONE
    if_pend = 1'b1; if_a = 32'h20;
    d_pend = 1'b1; d_we = 1'b0; d_a = 32'h10;
    run(8);

    // both requesters always busy: starvation run length
    if_mode = 2; d_mode = 2;
    run(24);
`ifdef MEM_ARB_RR_EN
    exp_run = 1;
`else
    exp_run = STARVE_MAX;
`endif
    chk("starve_run", 32'(run_len), 32'(exp_run));
    if_mode = 0; d_mode = 0;
    run(10);

    // sw 0x14 then lw 0x14 reads it back
    d_pend = 1'b1; d_we = 1'b1; d_a = 32'h14; d_wd = 32'hDEAD_BEEF;
    run(5);
    d_pend = 1'b1; d_we = 1'b0; d_a = 32'h14;
    run(5);

    // random traffic, aligned
    if_mode = 1; d_mode = 1;
    run(400);
    if_mode = 0; d_mode = 0;
    run(10);

    // misaligned load 0x13, then random traffic with the flag sticky
    d_pend = 1'b1; d_we = 1'b0; d_a = 32'h13;
    run(5);
    allow_mis = 1'b1; if_mode = 1; d_mode = 1;
    run(200);
    if_mode = 0; d_mode = 0; allow_mis = 1'b0;
    run(10);

    // reset while a fetch sits in WAIT, then a fresh fetch
    if_pend = 1'b1; if_a = 32'h8;
    run(2);
    do_reset(2);
    if_pend = 1'b1; if_a = 32'h4;
    run(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 2, memory read latency in cycles from mem_en_o to mem_rdata_i valid; legal range 1..8.
REQ-002 Parameter: STARVE_MAX, default 3, maximum consecutive data grants while IF is waiting.
REQ-003 Port: clk_i  in  1  clock; the single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset; asynchronous, active-low.
REQ-005 Port: if_req_i  in  1  instruction-fetch request; held until if_gnt_o.
REQ-006 Port: if_addr_i  in  32  fetch byte address.
REQ-007 Port: if_gnt_o  out  1  fetch request accepted this cycle.
REQ-008 Port: if_valid_o  out  1  one-cycle pulse; if_rdata_o valid.
REQ-009 Port: if_rdata_o  out  32  fetched word.
REQ-010 Port: d_req_i  in  1  data (lw/sw) request; held until d_gnt_o.
REQ-011 Port: d_we_i  in  1  1 = store, 0 = load.
REQ-012 Port: d_addr_i  in  32  data byte address.
REQ-013 Port: d_wdata_i  in  32  store data.
REQ-014 Port: d_gnt_o  out  1  data request accepted this cycle.
REQ-015 Port: d_valid_o  out  1  one-cycle completion pulse (load data or store acknowledge).
REQ-016 Port: d_rdata_o  out  32  loaded word.
REQ-017 Port: mem_en_o, mem_we_o  out  1 each  single-cycle memory strobe and write enable.
REQ-018 Port: mem_addr_o, mem_wdata_o  out  32 each  word-aligned address and write data.
REQ-019 Port: mem_rdata_i  in  32  memory read data.
REQ-020 Port: misalign_o  out  1  sticky flag; an accepted request had addr[1:0] != 0.

Function
REQ-021 FSM states: IDLE, WAIT, DONE; at most one transaction outstanding.
REQ-022 In IDLE or DONE, a pending request is granted combinationally: gnt_o, mem_en_o, mem_we_o (data stores only), mem_addr_o and mem_wdata_o all assert in the same cycle; the FSM then moves to WAIT.
REQ-023 mem_addr_o SHALL be {addr[31:2],2'b00}; an accepted request with addr[1:0] != 0 sets misalign_o.
REQ-024 WAIT loads a down-counter with MEM_LAT-1 and moves to DONE when the counter reaches 0, registering mem_rdata_i on that edge.
REQ-025 DONE asserts the granted requester's valid_o for exactly one cycle; end-to-end latency is gnt at cycle t -> valid_o at cycle t+MEM_LAT+1.
REQ-026 rdata_o holds its last value until the next completion.
REQ-027 Back-to-back: a grant issued in DONE makes the next state WAIT; otherwise DONE -> IDLE.
REQ-028 Arbitration: fixed priority to data, except when the starvation counter equals STARVE_MAX with if_req_i high; IF then wins.
REQ-029 Starvation counter: increments on each data grant while if_req_i is high; clears on any IF grant; saturates at STARVE_MAX.
REQ-030 Requests arriving in WAIT are not granted; gnt_o stays 0.
REQ-031 Store completion: d_valid_o pulses and d_rdata_o is unchanged.

Reset
REQ-032 Assertion of rst_n = 0 at any time SHALL force IDLE, clear counters and misalign_o, drive all *_o to 0, and drop any outstanding transaction without a valid pulse.
REQ-033 The first grant is possible in the first cycle after rst_n rises.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: arbitration is strict round-robin; on contention the requester not granted last wins; the starvation counter and STARVE_MAX are unused.
REQ-035 MEM_ARB_RR_EN undefined: arbitration follows REQ-028 and REQ-029.

Structure
REQ-036 The shared package holds the FSM state enum, the requester-ID enum (REQ_IF, REQ_D) and the MEM_LAT legal-range constants.
REQ-037 One sub-module, mem_arb_pick, performs winner selection (priority/starvation or round-robin); the FSM and datapath stay in mem_port_arbiter.

Verification
REQ-038 Single fetch of addr 0x8 with MEM_LAT=2: gnt at t, mem_addr_o=0x8, if_valid_o at t+3 with mem_rdata_i data.
REQ-039 Simultaneous if_req_i and d_req_i (lw 0x10), default build: d_gnt_o first, IF granted in DONE of the load, no idle cycle.
REQ-040 Continuous d_req_i with if_req_i held, STARVE_MAX=3: exactly 3 data grants, then 1 IF grant.
REQ-041 sw 0x14 data 0xDEADBEEF: mem_we_o=1 and mem_wdata_o=0xDEADBEEF for one cycle; d_valid_o at t+MEM_LAT+1.
REQ-042 Load at 0x13: mem_addr_o=0x10 and misalign_o stays 1 until reset.
REQ-043 rst_n pulled low during WAIT: no valid pulse, all outputs 0; a new fetch after release completes normally.
